// File: rtl/scaler_video_out.sv
// rtl/scaler_video_out.sv - FIFO-buffered replay of the scaled pixel stream onto a fixed display raster
module scaler_video_out #(
    parameter int   DATA_WIDTH  = 8,
    parameter int   FIFO_AW     = 11,
    parameter int   START_LEVEL = 1024,
    parameter int   H_ACTIVE    = 800,
    parameter int   H_FP        = 40,
    parameter int   H_SYNC      = 128,
    parameter int   H_BP        = 88,
    parameter int   V_ACTIVE    = 600,
    parameter int   V_FP        = 1,
    parameter int   V_SYNC      = 4,
    parameter int   V_BP        = 23,
    parameter logic SYNC_POL    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tvalid_i,
    input  logic [DATA_WIDTH-1:0] tdata_i,
    input  logic                  tvsync_i,
    output logic                  tready_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  de_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEPTH   = 1 << FIFO_AW;

    localparam logic [1:0] S_WAIT_FRAME = 2'd0;
    localparam logic [1:0] S_PRIME      = 2'd1;
    localparam logic [1:0] S_RUN        = 2'd2;

    logic [15:0]           h_cnt;
    logic [15:0]           v_cnt;
    logic [1:0]            state;
    logic                  tvsync_q;
    logic                  starved;
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW:0]      count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic full, empty, h_last, v_last, frame_start, active;
    logic h_sync_zone, v_sync_zone, tvsync_rise;
    logic go, stop, running, rd_en, wr_en, flush;

    assign full        = (count == (FIFO_AW+1)'(DEPTH));
    assign empty       = (count == '0);
    assign tready_o    = ~full;
    assign h_last      = (h_cnt == 16'(H_TOTAL - 1));
    assign v_last      = (v_cnt == 16'(V_TOTAL - 1));
    assign frame_start = (h_cnt == 16'd0) && (v_cnt == 16'd0);
    assign active      = (h_cnt < 16'(H_ACTIVE)) && (v_cnt < 16'(V_ACTIVE));
    assign h_sync_zone = (h_cnt >= 16'(H_ACTIVE + H_FP)) && (h_cnt < 16'(H_ACTIVE + H_FP + H_SYNC));
    assign v_sync_zone = (v_cnt >= 16'(V_ACTIVE + V_FP)) && (v_cnt < 16'(V_ACTIVE + V_FP + V_SYNC));
    assign tvsync_rise = tvsync_i && !tvsync_q;

    // PRIME hands over to RUN in the frame-start cycle itself so pixel (0,0) is read.
    // A frame that starved leaves RUN at the next frame start without driving it.
    assign go      = (state == S_PRIME) && frame_start && (count >= (FIFO_AW+1)'(START_LEVEL));
    assign stop    = (state == S_RUN) && frame_start && starved;
    assign running = ((state == S_RUN) && !stop) || go;
    assign rd_en   = running && active && !empty;
    assign wr_en   = tvalid_i && !full && (state != S_WAIT_FRAME);
    assign flush   = (state == S_WAIT_FRAME) || stop;

    // Free-running raster position
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? 16'd0 : v_cnt + 16'd1;
        end else begin
            h_cnt <= h_cnt + 16'd1;
        end
    end

    // Frame lock state machine and per-frame starvation marker
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_WAIT_FRAME;
            tvsync_q <= 1'b0;
            starved  <= 1'b0;
        end else begin
            tvsync_q <= tvsync_i;
            if (!running)
                starved <= 1'b0;
            else if (active && empty)
                starved <= 1'b1;
            case (state)
                S_WAIT_FRAME: if (tvsync_rise) state <= S_PRIME;
                S_PRIME:      if (go)          state <= S_RUN;
                S_RUN:        if (stop)        state <= S_WAIT_FRAME;
                default:                       state <= S_WAIT_FRAME;
            endcase
        end
    end

    // FIFO pointers and occupancy; held empty while waiting for a frame
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr] <= tdata_i;
    end

    // Registered, mutually aligned display outputs and sticky error flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hsync_o     <= ~SYNC_POL;
            vsync_o     <= ~SYNC_POL;
            de_o        <= 1'b0;
            data_o      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            hsync_o <= h_sync_zone ? SYNC_POL : ~SYNC_POL;
            vsync_o <= v_sync_zone ? SYNC_POL : ~SYNC_POL;
            de_o    <= running && active;
            data_o  <= rd_en ? mem[rd_ptr] : '0;
            if (tvalid_i && full)
                overflow_o <= 1'b1;
            if (running && active && empty)
                underflow_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_scaler_video_out.sv
// tb/tb_scaler_video_out.sv - randomized and directed checks of scaler_video_out against a queue-based model
module tb_scaler_video_out;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int DEPTH = 64;
    localparam int START = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tvalid = 1'b0;
    logic [7:0] tdata = 8'd0;
    logic       tvsync = 1'b0;
    logic       tready, hsync, vsync, de, overflow, underflow;
    logic [7:0] data;

    int checks = 0;
    int failures = 0;

    // reference model state
    int unsigned t;
    int          mode;
    bit          m_prev_vs, m_starved, m_ovf, m_unf, m_de, m_hs, m_vs;
    logic [7:0]  m_data;
    logic [7:0]  q[$];
    logic [7:0]  cap[$];
    logic [7:0]  sent[$];

    scaler_video_out #(
        .DATA_WIDTH(8), .FIFO_AW(6), .START_LEVEL(START),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .tvalid_i(tvalid), .tdata_i(tdata), .tvsync_i(tvsync),
        .tready_o(tready), .hsync_o(hsync), .vsync_o(vsync), .de_o(de), .data_o(data),
        .overflow_o(overflow), .underflow_o(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; mode = 0;
        m_prev_vs = 0; m_starved = 0; m_ovf = 0; m_unf = 0;
        m_de = 0; m_hs = 0; m_vs = 0; m_data = 8'd0;
        q.delete();
    endtask

    // One clock of the model: what the design should show after this edge.
    task automatic model_edge();
        int  h, v, next_mode;
        bit  fs, act, rise, was_full, run_now;
        h = int'(t % HT);
        v = int'((t / HT) % VT);
        fs = (h == 0) && (v == 0);
        act = (h < HA) && (v < VA);
        rise = tvsync && !m_prev_vs;
        was_full = (q.size() == DEPTH);
        next_mode = mode;
        run_now = 0;
        if (mode == 1 && fs && q.size() >= START) begin
            run_now = 1; next_mode = 2;
        end else if (mode == 2) begin
            if (fs && m_starved) next_mode = 0;
            else run_now = 1;
        end else if (mode == 0 && rise) begin
            next_mode = 1;
        end
        m_de = run_now && act;
        m_data = 8'd0;
        if (m_de) begin
            if (q.size() > 0) m_data = q.pop_front();
            else begin m_unf = 1; m_starved = 1; end
        end
        if (tvalid) begin
            if (was_full) m_ovf = 1;
            else if (mode != 0) q.push_back(tdata);
        end
        if (next_mode == 0) begin q.delete(); m_starved = 0; end
        m_hs = (h >= HA + HF) && (h < HA + HF + HS);
        m_vs = (v >= VA + VF) && (v < VA + VF + VS);
        m_prev_vs = tvsync;
        mode = next_mode;
        t++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("de", 32'(de), 32'(m_de));
        chk("data", 32'(data), 32'(m_data));
        chk("hsync", 32'(hsync), 32'(m_hs));
        chk("vsync", 32'(vsync), 32'(m_vs));
        chk("tready", 32'(tready), 32'(q.size() < DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        if (de) cap.push_back(data);
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; tvsync = 1'b0;
        #1;
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_tready", 32'(tready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        cap.delete();
        sent.delete();
    endtask

    task automatic pulse_tvsync();
        tvsync = 1'b1; step();
        tvsync = 1'b0; step();
    endtask

    task automatic wait_de(input int n, input int budget, input string tag);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(cap.size()), 32'(n));
    endtask

    initial begin
        int hs_cnt, vs_cnt, de_cnt, k;
        logic [7:0] v8;

        #3;
        do_reset();

        // raster with no input
        hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
        for (int i = 0; i < HT * VT; i++) begin
            step();
            hs_cnt += int'(hsync); vs_cnt += int'(vsync); de_cnt += int'(de);
        end
        chk("raster_hsync_clks", 32'(hs_cnt), 32'd14);
        chk("raster_vsync_clks", 32'(vs_cnt), 32'd14);
        chk("raster_de_clks", 32'(de_cnt), 32'd0);

        // 32 ordered pixels with random gaps
        do_reset();
        pulse_tvsync();
        k = 0;
        while (k < 32) begin
            tvalid = ($urandom_range(0, 3) != 0);
            tdata = 8'(k);
            step();
            if (tvalid) k++;
        end
        tvalid = 1'b0;
        wait_de(32, 400, "ordered_de_count");
        chk("ordered_underflow", 32'(underflow), 32'd0);
        for (int i = 0; i < 32; i++) begin
            v8 = (i < cap.size()) ? cap[i] : 8'hff;
            chk("ordered_pixel", 32'(v8), 32'(i));
        end

        // reset while RUN is driving active video
        do_reset();

        // fill beyond capacity with no reads
        pulse_tvsync();
        for (int i = 0; i < 70; i++) begin
            tvalid = 1'b1;
            tdata = 8'($urandom);
            sent.push_back(tdata);
            step();
            if (i == 62) chk("fill_tready_63", 32'(tready), 32'd1);
            if (i == 63) chk("fill_tready_64", 32'(tready), 32'd0);
        end
        tvalid = 1'b0;
        chk("fill_overflow", 32'(overflow), 32'd1);
        wait_de(64, 600, "fill_de_count");
        chk("fill_underflow", 32'(underflow), 32'd0);
        for (int i = 0; i < 64; i++) begin
            v8 = (i < cap.size()) ? cap[i] : ~sent[i];
            chk("fill_pixel", 32'(v8), 32'(sent[i]));
        end

        // starvation: only 10 pixels
        do_reset();
        pulse_tvsync();
        for (int i = 0; i < 10; i++) begin
            tvalid = 1'b1;
            tdata = 8'($urandom_range(1, 255));
            sent.push_back(tdata);
            step();
        end
        tvalid = 1'b0;
        repeat (4 * HT * VT) step();
        chk("starve_de_total", 32'(cap.size()), 32'd32);
        chk("starve_underflow", 32'(underflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            v8 = (i < cap.size()) ? cap[i] : 8'hee;
            chk("starve_pixel", 32'(v8), (i < 10) ? 32'(sent[i]) : 32'd0);
        end

        // tvsync rise during RUN is ignored
        do_reset();
        pulse_tvsync();
        for (int i = 0; i < 40; i++) begin
            tvalid = 1'b1;
            tdata = 8'($urandom);
            sent.push_back(tdata);
            step();
        end
        tvalid = 1'b0;
        wait_de(10, 300, "resync_pre_de");
        pulse_tvsync();
        wait_de(32, 300, "resync_de_count");
        chk("resync_underflow", 32'(underflow), 32'd0);
        for (int i = 0; i < 32; i++) begin
            v8 = (i < cap.size()) ? cap[i] : ~sent[i];
            chk("resync_pixel", 32'(v8), 32'(sent[i]));
        end
        repeat (40) step();

        // free-running random traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            tvalid = ($urandom_range(0, 1) == 1);
            tdata = 8'($urandom);
            if ($urandom_range(0, 60) == 0) tvsync = ~tvsync;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
